// File: rtl/wb_dram_arbiter.sv
// wb_dram_arbiter
//   Round-robin arbiter sharing the single Wishbone port of the DRAM wrapper
//   between NUM_MASTERS requesters. One transaction is in flight at a time.
//   A per-transaction watchdog converts a hung downstream access into an
//   error pulse to the requester. No grant is issued until the DRAM reports
//   initialized. Everything runs on the rising edge of sys_clk.
//
// Ports
//   sys_clk, rst_n      clock, asynchronous active-low reset
//   initialized_i       DRAM ready; gates new grants only
//   m_cyc_i / m_stb_i   per-master request (cyc & stb)
//   m_we_i              per-master write enable
//   m_addr_i, m_data_i  packed per-master address / write data (slice i)
//   m_data_o            shared read data, valid with the owning m_ack_o bit
//   m_ack_o, m_err_o    one-cycle acknowledge / timeout error per master
//   s_cyc_o .. s_data_o downstream request (registered, held while issued)
//   s_data_i, s_ack_i   downstream response
//   busy_o              high whenever the arbiter is not idle
module wb_dram_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int WORD_SIZE      = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                              sys_clk,
  input  logic                              rst_n,
  input  logic                              initialized_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*WORD_SIZE-1:0]  m_data_i,
  output logic [WORD_SIZE-1:0]              m_data_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [WORD_SIZE-1:0]              s_data_o,
  input  logic [WORD_SIZE-1:0]              s_data_i,
  input  logic                              s_ack_i,
  output logic                              busy_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DRAIN   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       grant, grant_nxt;
  logic [IDX_W-1:0]       last_grant, last_grant_nxt;
  logic [CNT_W-1:0]       wdog, wdog_nxt;

  logic                   s_cyc_nxt, s_stb_nxt, s_we_nxt;
  logic [ADDR_WIDTH-1:0]  s_addr_nxt;
  logic [WORD_SIZE-1:0]   s_data_nxt;
  logic [WORD_SIZE-1:0]   m_data_nxt;
  logic [NUM_MASTERS-1:0] m_ack_nxt, m_err_nxt;

  logic [NUM_MASTERS-1:0] req;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       cand;

  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_MASTERS];
  logic [WORD_SIZE-1:0]   wdata_arr [NUM_MASTERS];

  // Unpack the flat per-master buses so the winner can be selected by index.
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_arr[g]  = m_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = m_data_i[g*WORD_SIZE +: WORD_SIZE];
  end

  assign req    = m_cyc_i & m_stb_i;
  assign busy_o = (state != IDLE);

  // Round-robin pick: scan starting one past the last served master so the
  // most recently served requester has the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_MASTERS);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    wdog_nxt       = wdog;
    s_cyc_nxt      = s_cyc_o;
    s_stb_nxt      = s_stb_o;
    s_we_nxt       = s_we_o;
    s_addr_nxt     = s_addr_o;
    s_data_nxt     = s_data_o;
    m_data_nxt     = m_data_o;
    m_ack_nxt      = '0;
    m_err_nxt      = '0;

    case (state)
      IDLE: begin
        if (initialized_i && win_found) begin
          state_nxt  = ISSUE;
          grant_nxt  = win_idx;
          wdog_nxt   = '0;
          s_cyc_nxt  = 1'b1;
          s_stb_nxt  = 1'b1;
          s_we_nxt   = m_we_i[win_idx];
          s_addr_nxt = addr_arr[win_idx];
          s_data_nxt = wdata_arr[win_idx];
        end
      end

      ISSUE: begin
        // An ack arriving on the very cycle the watchdog expires wins.
        if (s_ack_i) begin
          state_nxt         = HOLDOFF;
          s_cyc_nxt         = 1'b0;
          s_stb_nxt         = 1'b0;
          s_we_nxt          = 1'b0;
          m_data_nxt        = s_data_i;
          m_ack_nxt[grant]  = 1'b1;
          last_grant_nxt    = grant;
          wdog_nxt          = '0;
        end else if (wdog == WDOG_LAST) begin
          state_nxt         = DRAIN;
          s_cyc_nxt         = 1'b0;
          s_stb_nxt         = 1'b0;
          m_err_nxt[grant]  = 1'b1;
          last_grant_nxt    = grant;
          wdog_nxt          = '0;
        end else begin
          wdog_nxt = wdog + CNT_W'(1);
        end
      end

      // The DRAM already accepted the request; swallow its late ack and data.
      DRAIN: begin
        if (s_ack_i) begin
          state_nxt = HOLDOFF;
        end
      end

      // One dead cycle so the served master can drop stb before re-arbitration.
      HOLDOFF: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_INIT;
      wdog       <= '0;
      s_cyc_o    <= 1'b0;
      s_stb_o    <= 1'b0;
      s_we_o     <= 1'b0;
      s_addr_o   <= '0;
      s_data_o   <= '0;
      m_data_o   <= '0;
      m_ack_o    <= '0;
      m_err_o    <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      wdog       <= wdog_nxt;
      s_cyc_o    <= s_cyc_nxt;
      s_stb_o    <= s_stb_nxt;
      s_we_o     <= s_we_nxt;
      s_addr_o   <= s_addr_nxt;
      s_data_o   <= s_data_nxt;
      m_data_o   <= m_data_nxt;
      m_ack_o    <= m_ack_nxt;
      m_err_o    <= m_err_nxt;
    end
  end

endmodule

// File: tb/tb_wb_dram_arbiter.sv
// Self-checking bench for wb_dram_arbiter. The bench plays all requesting
// masters and the downstream DRAM port; a round-robin reference model
// predicts the winner, the forwarded request and the response of each
// transaction.
module tb_wb_dram_arbiter;

  localparam int NM = 4;
  localparam int WS = 256;
  localparam int AW = 32;
  localparam int TO = 16;

  logic             sys_clk;
  logic             rst_n;
  logic             initialized_i;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*WS-1:0] m_data;
  logic [WS-1:0]    m_data_o;
  logic [NM-1:0]    m_ack_o, m_err_o;
  logic             s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]    s_addr_o;
  logic [WS-1:0]    s_data_o;
  logic [WS-1:0]    s_data_i;
  logic             s_ack_i;
  logic             busy_o;

  // Per-master requester state driven by the bench.
  logic          cyc_q  [NM];
  logic          stb_q  [NM];
  logic          we_q   [NM];
  logic [AW-1:0] addr_q [NM];
  logic [WS-1:0] data_q [NM];

  for (genvar g = 0; g < NM; g++) begin : g_pack
    assign m_cyc[g]             = cyc_q[g];
    assign m_stb[g]             = stb_q[g];
    assign m_we[g]              = we_q[g];
    assign m_addr[g*AW +: AW]   = addr_q[g];
    assign m_data[g*WS +: WS]   = data_q[g];
  end

  wb_dram_arbiter #(
    .NUM_MASTERS    (NM),
    .WORD_SIZE      (WS),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .initialized_i (initialized_i),
    .m_cyc_i       (m_cyc),
    .m_stb_i       (m_stb),
    .m_we_i        (m_we),
    .m_addr_i      (m_addr),
    .m_data_i      (m_data),
    .m_data_o      (m_data_o),
    .m_ack_o       (m_ack_o),
    .m_err_o       (m_err_o),
    .s_cyc_o       (s_cyc_o),
    .s_stb_o       (s_stb_o),
    .s_we_o        (s_we_o),
    .s_addr_o      (s_addr_o),
    .s_data_o      (s_data_o),
    .s_data_i      (s_data_i),
    .s_ack_i       (s_ack_i),
    .busy_o        (busy_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: last served master and last delivered read data.
  int         model_last  = NM - 1;
  logic [WS-1:0] model_rdata = '0;

  task automatic check(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [WS-1:0] rand256();
    logic [WS-1:0] r;
    r = '0;
    for (int i = 0; i < WS / 32; i++) r = (r << 32) | WS'($urandom);
    return r;
  endfunction

  function automatic logic [NM-1:0] onehot(input int i);
    return NM'(1) << i;
  endfunction

  // First requesting master found scanning upward from last+1, modulo NM.
  function automatic int rr_pick(input int last);
    for (int k = 1; k <= NM; k++) begin
      int c;
      c = (last + k) % NM;
      if (cyc_q[c] && stb_q[c]) return c;
    end
    return -1;
  endfunction

  function automatic int req_count();
    int n;
    n = 0;
    for (int i = 0; i < NM; i++) if (cyc_q[i] && stb_q[i]) n++;
    return n;
  endfunction

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [WS-1:0] d);
    cyc_q[i]  = 1'b1;
    stb_q[i]  = 1'b1;
    we_q[i]   = we;
    addr_q[i] = a;
    data_q[i] = d;
  endtask

  task automatic clear_req();
    for (int i = 0; i < NM; i++) begin
      cyc_q[i] = 1'b0;
      stb_q[i] = 1'b0;
      we_q[i]  = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cyc"},  WS'(s_cyc_o),  WS'(0));
    check({tag, "_stb"},  WS'(s_stb_o),  WS'(0));
    check({tag, "_we"},   WS'(s_we_o),   WS'(0));
    check({tag, "_addr"}, WS'(s_addr_o), WS'(0));
    check({tag, "_wdat"}, s_data_o,      WS'(0));
    check({tag, "_rdat"}, m_data_o,      WS'(0));
    check({tag, "_ack"},  WS'(m_ack_o),  WS'(0));
    check({tag, "_err"},  WS'(m_err_o),  WS'(0));
    check({tag, "_busy"}, WS'(busy_o),   WS'(0));
  endtask

  // One full transaction, entered in an IDLE cycle with requests already
  // driven; returns in the IDLE cycle after HOLDOFF.
  //   dly        : cycles from the first s_stb_o cycle to s_ack_i
  //   rd         : read data presented with s_ack_i
  //   drop_after : winner drops its request once answered
  //   drop_early : winner drops cyc/stb right after being granted
  //   init_glitch: initialized_i low while the access is outstanding
  task automatic run_txn(input int dly, input logic [WS-1:0] rd, input bit drop_after,
                         input bit drop_early, input bit init_glitch);
    int w;
    check("req_present", WS'(req_count() > 0), WS'(1));
    w = rr_pick(model_last);
    if (w < 0) return;
    tick();
    check("stb_rise", WS'(s_stb_o), WS'(1));
    check("cyc_rise", WS'(s_cyc_o), WS'(1));
    check("addr", WS'(s_addr_o), WS'(addr_q[w]));
    check("we", WS'(s_we_o), WS'(we_q[w]));
    check("wdata", s_data_o, data_q[w]);
    check("busy_issue", WS'(busy_o), WS'(1));
    if (init_glitch) initialized_i = 1'b0;
    if (drop_early) begin
      cyc_q[w] = 1'b0;
      stb_q[w] = 1'b0;
    end
    if (dly < TO) begin
      repeat (dly) tick();
      check("stb_hold", WS'(s_stb_o), WS'(1));
      check("addr_hold", WS'(s_addr_o), WS'(addr_q[w]));
      check("ack_early", WS'(m_ack_o), WS'(0));
      s_ack_i  = 1'b1;
      s_data_i = rd;
      tick();
      s_ack_i  = 1'b0;
      s_data_i = rand256();
      check("ack", WS'(m_ack_o), WS'(onehot(w)));
      check("err_none", WS'(m_err_o), WS'(0));
      check("rdata", m_data_o, rd);
      check("stb_clr", WS'(s_stb_o), WS'(0));
      check("cyc_clr", WS'(s_cyc_o), WS'(0));
      check("we_clr", WS'(s_we_o), WS'(0));
      model_rdata = rd;
    end else begin
      repeat (TO - 1) tick();
      check("stb_before_to", WS'(s_stb_o), WS'(1));
      tick();
      check("err", WS'(m_err_o), WS'(onehot(w)));
      check("ack_on_to", WS'(m_ack_o), WS'(0));
      check("stb_to", WS'(s_stb_o), WS'(0));
      check("cyc_to", WS'(s_cyc_o), WS'(0));
      repeat (dly - TO) begin
        tick();
        check("drain_quiet", WS'({m_ack_o, m_err_o, s_stb_o}), WS'(0));
      end
      s_ack_i  = 1'b1;
      s_data_i = rd;
      tick();
      s_ack_i  = 1'b0;
      s_data_i = rand256();
      check("drain_noack", WS'(m_ack_o), WS'(0));
      check("drain_noerr", WS'(m_err_o), WS'(0));
      check("drain_data", m_data_o, model_rdata);
    end
    model_last = w;
    if (init_glitch) initialized_i = 1'b1;
    if (drop_after) begin
      cyc_q[w] = 1'b0;
      stb_q[w] = 1'b0;
    end
    check("holdoff_busy", WS'(busy_o), WS'(1));
    tick();
    check("idle_busy", WS'(busy_o), WS'(0));
    check("idle_stb", WS'(s_stb_o), WS'(0));
    check("ack_pulse", WS'(m_ack_o), WS'(0));
    check("idle_data", m_data_o, model_rdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    rst_n         = 1'b0;
    initialized_i = 1'b0;
    s_ack_i       = 1'b0;
    s_data_i      = '0;
    for (int i = 0; i < NM; i++) begin
      cyc_q[i] = 1'b0; stb_q[i] = 1'b0; we_q[i] = 1'b0;
      addr_q[i] = '0;  data_q[i] = '0;
    end
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;

    // Single write from master 1.
    initialized_i = 1'b1;
    set_req(1, 1'b1, 32'h0000_0080, {32{8'hA5}});
    run_txn(5, rand256(), 1'b1, 1'b0, 1'b0);

    // Masters 0 and 2 keep requesting: they must alternate.
    set_req(0, 1'b0, 32'h0000_1000, rand256());
    set_req(2, 1'b1, 32'h0000_2000, rand256());
    repeat (4) run_txn(2, rand256(), 1'b0, 1'b0, 1'b0);
    clear_req();

    // Wrap-around: after master 3, master 0 beats master 3.
    set_req(3, 1'b1, 32'h0000_3000, rand256());
    run_txn(1, rand256(), 1'b1, 1'b0, 1'b0);
    set_req(3, 1'b1, 32'h0000_3040, rand256());
    set_req(0, 1'b1, 32'h0000_0040, rand256());
    run_txn(0, rand256(), 1'b1, 1'b0, 1'b0);
    run_txn(3, rand256(), 1'b1, 1'b0, 1'b0);

    // Read by master 3 with a known data word.
    set_req(3, 1'b0, 32'h0000_3100, '0);
    run_txn(4, 256'h1234, 1'b1, 1'b0, 1'b0);

    // Init gating, then a timeout absorbed in DRAIN, then a normal access.
    initialized_i = 1'b0;
    set_req(0, 1'b1, 32'h0000_0500, rand256());
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gate_stb", WS'(s_stb_o), WS'(0));
      check("gate_busy", WS'(busy_o), WS'(0));
    end
    initialized_i = 1'b1;
    run_txn(20, rand256(), 1'b1, 1'b0, 1'b0);
    set_req(1, 1'b0, 32'h0000_0600, rand256());
    run_txn(3, rand256(), 1'b1, 1'b0, 1'b0);

    // Reset while a transaction is outstanding.
    set_req(2, 1'b1, 32'h0000_0700, rand256());
    tick();
    check("pre_rst_stb", WS'(s_stb_o), WS'(1));
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    clear_req();
    model_last  = NM - 1;
    model_rdata = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NM; i++) set_req(i, 1'($urandom % 2), $urandom, rand256());
    run_txn(2, rand256(), 1'b1, 1'b0, 1'b0);
    clear_req();

    // Randomized traffic.
    for (int it = 0; it < 150; it++) begin
      int r;
      int dly;
      for (int i = 0; i < NM; i++)
        if (!(cyc_q[i] && stb_q[i]) && ($urandom % 3 == 0))
          set_req(i, 1'($urandom % 2), $urandom, rand256());
      if (req_count() == 0) begin
        tick();
        check("idle_no_req", WS'({busy_o, s_stb_o}), WS'(0));
      end else begin
        r = int'($urandom % 10);
        if (r < 7)       dly = int'($urandom % 6);
        else if (r == 7) dly = TO - 1;
        else             dly = TO + int'($urandom % 4);
        run_txn(dly, rand256(), ($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 6) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
